day10_light_solver: RTL and testbench
=====================================

Name: day10_light_solver

Overview:
- Sequencing controller for one day-10 machine description: light count, button count, per-button toggle masks and target light pattern.
- Accepts one machine per valid/ready handshake, then enumerates every button subset in Gray-code order, one subset per cycle.
- A single XOR accumulator and popcount register are updated each cycle; the block records the minimum press count that reaches the target.
- Returns the per-machine result on a valid/ready output and keeps a running total for the puzzle answer.

Parameters:
- MAX_NUM_LIGHTS, 10, maximum lights per machine; width of masks and target.
- MAX_NUM_BUTTONS, 13, maximum buttons per machine.
- MAX_NUM_BUTTONS_W, (MAX_NUM_BUTTONS<=1 ? 1 : $clog2(MAX_NUM_BUTTONS+1)), width of button counts and press counts.
- MAX_NUM_LIGHTS_W, (MAX_NUM_LIGHTS<=1 ? 1 : $clog2(MAX_NUM_LIGHTS+1)), width of the light count.
- SUM_W, 32, width of the running total.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  machine description valid.
- in_ready  output  1  high only in IDLE.
- in_num_lights  input  MAX_NUM_LIGHTS_W  lights in use, bits [num_lights-1:0].
- in_num_buttons  input  MAX_NUM_BUTTONS_W  buttons in use, entries [num_buttons-1:0].
- in_buttons  input  MAX_NUM_LIGHTS x MAX_NUM_BUTTONS unpacked  toggle mask per button; bit i toggles light i.
- in_target  input  MAX_NUM_LIGHTS  target pattern; light 0 is the leftmost character, bit 0.
- out_valid  output  1  result valid (DONE).
- out_ready  input  1  result consumed.
- out_found  output  1  at least one subset reaches the target.
- out_min_presses  output  MAX_NUM_BUTTONS_W  minimum presses; 0 when out_found=0.
- busy  output  1  state != IDLE.
- total_clear  input  1  synchronous clear of total_presses.
- total_presses  output  SUM_W  sum of out_min_presses over all consumed results with out_found=1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_found=0, out_min_presses=0, busy=0, total_presses=0.
  - All captured machine data is discarded.
  - Reset asserted mid-SEARCH or mid-DONE aborts immediately with no result; the total is unchanged except for the clear to 0.
- IDLE:
  - On in_valid && in_ready, register all inputs.
  - Mask the target and every button with ((1<<num_lights)-1).
  - Treat buttons at index >= num_buttons as all-zero.
  - Clear acc=0, cnt=0, k=0, found=0, min=0. Go to SEARCH.
- SEARCH, once per cycle:
  - Evaluate the current subset: if acc==target and (!found || cnt<min), then found<=1 and min<=cnt.
  - If k == 2^num_buttons - 1, go to DONE.
  - Otherwise set j = count of trailing zeros of (k+1).
  - If bit j of the subset register is currently clear: set it, acc^=button[j], cnt+=1. If it is set: clear it, acc^=button[j], cnt-=1.
  - Then k+=1.
- Cycle counts:
  - SEARCH lasts exactly 2^num_buttons cycles.
  - out_valid rises exactly 2^num_buttons + 1 clock edges after the accepting edge.
  - num_buttons=0: one SEARCH cycle evaluates only the empty subset.
- Width rules:
  - k is MAX_NUM_BUTTONS+1 bits wide, so 2^MAX_NUM_BUTTONS - 1 is reachable without wrap.
  - cnt never exceeds num_buttons and never underflows.
- DONE:
  - out_valid=1; out_found and out_min_presses are held stable until out_valid && out_ready.
  - On that handshake, return to IDLE and, if out_found, total_presses += out_min_presses (modulo 2^SUM_W).
  - in_ready stays low in DONE; there is no input/output overlap.
- total_clear:
  - Effective in any state.
  - If it coincides with a consuming handshake, total_presses <= that result's contribution (clear first, then add).
  - Otherwise total_presses <= 0.
- Special inputs:
  - An all-zero target is always found with min=0 (empty subset).
  - An unreachable target gives out_found=0, out_min_presses=0, and adds nothing to the total.
  - Inputs are ignored outside IDLE.

Test Plan:
- Machine [.##.], buttons (3)(1,3)(2)(2,3)(0,2)(0,1): num_lights=4, num_buttons=6, target=4'b0110 -> out_found=1, out_min_presses=2, out_valid exactly 65 edges after accept, total_presses=2.
- Back-to-back: [...#.] (0,2,3,4)(2,3)(0,4)(0,1,2)(1,2,3,4) -> 3; then [.###.#] (0,1,2,3,4)(0,3,4)(0,1,2,4,5)(1,2) -> 2; with the previous machine, total_presses=7 after the third handshake.
- Unreachable case: target=4'b0001, single button 4'b0011 -> out_found=0, out_min_presses=0, total unchanged. Zero-button case: num_buttons=0, target=0 -> found, min=0, out_valid 2 edges after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; the release consumes the result exactly once.
- Reset at SEARCH cycle 20 -> all outputs return to reset values asynchronously; a new machine afterwards gives correct results. Separately: total_clear coincident with consuming a min=2 result -> total_presses=2.
- Masking: num_lights=3 with garbage in button bit 5 and target bit 7 -> bits ignored, result matches the clean-input reference model.

Source files
------------

// File: rtl/day10_light_solver.sv
// Day-10 light solver: accepts one machine description, walks every button
// subset in Gray-code order (one subset per cycle) keeping a single XOR
// accumulator and press count, and reports the minimum press count that
// lights exactly the target pattern. A running total of consumed results
// is kept for the puzzle answer.
module day10_light_solver #(
  parameter int MAX_NUM_LIGHTS    = 10,
  parameter int MAX_NUM_BUTTONS   = 13,
  parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1 ? 1 : $clog2(MAX_NUM_BUTTONS + 1)),
  parameter int MAX_NUM_LIGHTS_W  = (MAX_NUM_LIGHTS <= 1 ? 1 : $clog2(MAX_NUM_LIGHTS + 1)),
  parameter int SUM_W             = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MAX_NUM_LIGHTS_W-1:0]  in_num_lights,
  input  logic [MAX_NUM_BUTTONS_W-1:0] in_num_buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]    in_buttons [MAX_NUM_BUTTONS],
  input  logic [MAX_NUM_LIGHTS-1:0]    in_target,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_found,
  output logic [MAX_NUM_BUTTONS_W-1:0] out_min_presses,
  output logic                         busy,
  input  logic                         total_clear,
  output logic [SUM_W-1:0]             total_presses
);

  // Subset index is one bit wider than the button count so the final
  // subset 2^MAX_NUM_BUTTONS-1 is representable without wrapping.
  localparam int KW = MAX_NUM_BUTTONS + 1;

  // FINISH is a one-cycle settle stage that copies the search result into
  // the output registers, so DONE presents values that cannot move.
  typedef enum logic [1:0] {IDLE, SEARCH, FINISH, DONE} state_t;

  state_t                         state, state_next;
  logic [MAX_NUM_LIGHTS-1:0]      buttons_q [MAX_NUM_BUTTONS];
  logic [MAX_NUM_LIGHTS-1:0]      target_q, acc_q, light_mask;
  logic [MAX_NUM_BUTTONS_W-1:0]   num_buttons_q, cnt_q, min_q, flip_idx;
  logic [MAX_NUM_BUTTONS-1:0]     subset_q;
  logic [KW-1:0]                  k_q, k_inc, k_last;
  logic                           found_q, hit, accept, consume;
  logic                           out_found_q;
  logic [MAX_NUM_BUTTONS_W-1:0]   out_min_q;
  logic [SUM_W-1:0]               contrib;

  assign in_ready        = (state == IDLE);
  assign out_valid       = (state == DONE);
  assign busy            = (state != IDLE);
  assign accept          = in_valid && in_ready;
  assign consume         = out_valid && out_ready;
  assign out_found       = out_found_q;
  assign out_min_presses = out_min_q;
  assign contrib         = out_found_q ? SUM_W'(out_min_q) : '0;

  // Search helpers: mask of live lights, last subset index, Gray flip bit
  // (trailing zeros of k+1) and whether the current subset improves the best.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    light_mask = MAX_NUM_LIGHTS'((32'd1 << in_num_lights) - 32'd1);
    k_last     = (KW'(1) << num_buttons_q) - KW'(1);
    k_inc      = k_q + KW'(1);
    flip_idx   = '0;
    for (int i = MAX_NUM_BUTTONS - 1; i >= 0; i--) begin
      if (k_inc[i]) flip_idx = MAX_NUM_BUTTONS_W'(i);
    end
    hit = (acc_q == target_q) && (!found_q || (cnt_q < min_q));
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)         state_next = SEARCH;
      SEARCH:  if (k_q == k_last)    state_next = FINISH;
      FINISH:                        state_next = DONE;
      DONE:    if (out_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Machine capture and the per-cycle Gray-code walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the button table is small and must be discarded on reset, so
      // it is reset like ordinary flops rather than left as uninitialised RAM.
      for (int b = 0; b < MAX_NUM_BUTTONS; b++) buttons_q[b] <= '0;
      target_q      <= '0;
      acc_q         <= '0;
      num_buttons_q <= '0;
      cnt_q         <= '0;
      min_q         <= '0;
      subset_q      <= '0;
      k_q           <= '0;
      found_q       <= 1'b0;
      out_found_q   <= 1'b0;
      out_min_q     <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          for (int b = 0; b < MAX_NUM_BUTTONS; b++)
            buttons_q[b] <= (b < 32'(in_num_buttons)) ? (in_buttons[b] & light_mask) : '0;
          target_q      <= in_target & light_mask;
          num_buttons_q <= in_num_buttons;
          acc_q         <= '0;
          cnt_q         <= '0;
          min_q         <= '0;
          subset_q      <= '0;
          k_q           <= '0;
          found_q       <= 1'b0;
        end
        SEARCH: begin
          if (hit) begin
            found_q <= 1'b1;
            min_q   <= cnt_q;
          end
          if (k_q != k_last) begin
            subset_q[flip_idx] <= ~subset_q[flip_idx];
            acc_q              <= acc_q ^ buttons_q[flip_idx];
            cnt_q              <= subset_q[flip_idx] ? cnt_q - MAX_NUM_BUTTONS_W'(1)
                                                     : cnt_q + MAX_NUM_BUTTONS_W'(1);
            k_q                <= k_inc;
          end
        end
        FINISH: begin
          out_found_q <= found_q;
          out_min_q   <= found_q ? min_q : '0;
        end
        DONE: if (out_ready) begin
          out_found_q <= 1'b0;
          out_min_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Running total: clear takes effect first, then the consumed result adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           total_presses <= '0;
    else if (consume)     total_presses <= (total_clear ? '0 : total_presses) + contrib;
    else if (total_clear) total_presses <= '0;
  end

endmodule

// File: tb/tb_day10_light_solver.sv
// Directed bench for day10_light_solver: puzzle example machines, latency,
// unreachable/zero-button corners, backpressure, mid-search reset,
// total_clear interaction and input masking.
module tb_day10_light_solver;

  localparam int NL  = 10;
  localparam int NB  = 13;
  localparam int NBW = 4;
  localparam int NLW = 4;
  localparam int SW  = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [NLW-1:0] in_num_lights;
  logic [NBW-1:0] in_num_buttons;
  logic [NL-1:0]  in_buttons [NB];
  logic [NL-1:0]  in_target;
  logic           out_valid;
  logic           out_ready;
  logic           out_found;
  logic [NBW-1:0] out_min_presses;
  logic           busy;
  logic           total_clear;
  logic [SW-1:0]  total_presses;

  int checks   = 0;
  int failures = 0;

  day10_light_solver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_num_lights  (in_num_lights),
    .in_num_buttons (in_num_buttons),
    .in_buttons     (in_buttons),
    .in_target      (in_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_found      (out_found),
    .out_min_presses(out_min_presses),
    .busy           (busy),
    .total_clear    (total_clear),
    .total_presses  (total_presses)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic clear_machine();
    for (int i = 0; i < NB; i++) in_buttons[i] = '0;
    in_target      = '0;
    in_num_lights  = '0;
    in_num_buttons = '0;
  endtask

  // [.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) -> 2
  task automatic load_m1();
    clear_machine();
    in_num_lights  = 4'd4;
    in_num_buttons = 4'd6;
    in_target      = 10'b0110;
    in_buttons[0]  = 10'b1000;
    in_buttons[1]  = 10'b1010;
    in_buttons[2]  = 10'b0100;
    in_buttons[3]  = 10'b1100;
    in_buttons[4]  = 10'b0101;
    in_buttons[5]  = 10'b0011;
  endtask

  // [...#.] (0,2,3,4) (2,3) (0,4) (0,1,2) (1,2,3,4) -> 3
  task automatic load_m2();
    clear_machine();
    in_num_lights  = 4'd5;
    in_num_buttons = 4'd5;
    in_target      = 10'b01000;
    in_buttons[0]  = 10'b11101;
    in_buttons[1]  = 10'b01100;
    in_buttons[2]  = 10'b10001;
    in_buttons[3]  = 10'b00111;
    in_buttons[4]  = 10'b11110;
  endtask

  // [.###.#] (0,1,2,3,4) (0,3,4) (0,1,2,4,5) (1,2) -> 2
  task automatic load_m3();
    clear_machine();
    in_num_lights  = 4'd6;
    in_num_buttons = 4'd4;
    in_target      = 10'b101110;
    in_buttons[0]  = 10'b011111;
    in_buttons[1]  = 10'b011001;
    in_buttons[2]  = 10'b110111;
    in_buttons[3]  = 10'b000110;
  endtask

  task automatic do_accept();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid; bounded.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20000) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic do_consume(input logic clr);
    @(negedge clk);
    out_ready   = 1'b1;
    total_clear = clr;
    @(posedge clk);
    #1;
    out_ready   = 1'b0;
    total_clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_found !== 1'b0 || out_min_presses !== '0 || total_presses !== '0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b found=%b min=%0d total=%0d expected 1 0 0 0 0 0",
               in_ready, out_valid, busy, out_found, out_min_presses, total_presses);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_example();
    int edges;
    load_m1();
    do_accept();
    wait_valid(edges);
    checks++;
    if (edges !== 65) begin
      failures++;
      $display("FAIL m1_latency: got %0d edges expected 65", edges);
    end
    checks++;
    if (out_found !== 1'b1 || out_min_presses !== 4'd2) begin
      failures++;
      $display("FAIL m1_result: found=%b min=%0d expected 1 2", out_found, out_min_presses);
    end
    do_consume(1'b0);
    checks++;
    if (total_presses !== 32'd2) begin
      failures++;
      $display("FAIL m1_total: got %0d expected 2", total_presses);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    load_m2();
    do_accept();
    wait_valid(edges);
    checks++;
    if (edges !== 33 || out_found !== 1'b1 || out_min_presses !== 4'd3) begin
      failures++;
      $display("FAIL m2_result: edges=%0d found=%b min=%0d expected 33 1 3", edges, out_found, out_min_presses);
    end
    do_consume(1'b0);
    load_m3();
    do_accept();
    wait_valid(edges);
    checks++;
    if (edges !== 17 || out_found !== 1'b1 || out_min_presses !== 4'd2) begin
      failures++;
      $display("FAIL m3_result: edges=%0d found=%b min=%0d expected 17 1 2", edges, out_found, out_min_presses);
    end
    do_consume(1'b0);
    checks++;
    if (total_presses !== 32'd7) begin
      failures++;
      $display("FAIL b2b_total: got %0d expected 7", total_presses);
    end
  endtask

  task automatic test_unreachable();
    int edges;
    clear_machine();
    in_num_lights  = 4'd4;
    in_num_buttons = 4'd1;
    in_target      = 10'b0001;
    in_buttons[0]  = 10'b0011;
    do_accept();
    wait_valid(edges);
    checks++;
    if (edges !== 3 || out_found !== 1'b0 || out_min_presses !== 4'd0) begin
      failures++;
      $display("FAIL unreachable: edges=%0d found=%b min=%0d expected 3 0 0", edges, out_found, out_min_presses);
    end
    do_consume(1'b0);
    checks++;
    if (total_presses !== 32'd7) begin
      failures++;
      $display("FAIL unreachable_total: got %0d expected 7", total_presses);
    end
  endtask

  task automatic test_zero_buttons();
    int edges;
    clear_machine();
    in_num_lights  = 4'd4;
    in_num_buttons = 4'd0;
    in_target      = 10'b0;
    in_buttons[0]  = 10'b1111;
    do_accept();
    wait_valid(edges);
    checks++;
    if (edges !== 2 || out_found !== 1'b1 || out_min_presses !== 4'd0) begin
      failures++;
      $display("FAIL zero_buttons: edges=%0d found=%b min=%0d expected 2 1 0", edges, out_found, out_min_presses);
    end
    do_consume(1'b0);
    checks++;
    if (total_presses !== 32'd7) begin
      failures++;
      $display("FAIL zero_buttons_total: got %0d expected 7", total_presses);
    end
  endtask

  task automatic test_backpressure();
    int edges;
    load_m1();
    do_accept();
    wait_valid(edges);
    @(negedge clk);
    load_m2();
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_found !== 1'b1 || out_min_presses !== 4'd2 ||
          in_ready !== 1'b0 || busy !== 1'b1 || total_presses !== 32'd7) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b found=%b min=%0d in_ready=%b busy=%b total=%0d expected 1 1 2 0 1 7",
                 c, out_valid, out_found, out_min_presses, in_ready, busy, total_presses);
      end
    end
    in_valid = 1'b0;
    do_consume(1'b0);
    checks++;
    if (total_presses !== 32'd9 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release: total=%0d valid=%b expected 9 0", total_presses, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (total_presses !== 32'd9 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_release: total=%0d busy=%b expected 9 0", total_presses, busy);
    end
  endtask

  task automatic test_reset_mid_search();
    int edges;
    load_m1();
    do_accept();
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_found !== 1'b0 || out_min_presses !== '0 || total_presses !== '0) begin
      failures++;
      $display("FAIL mid_reset: in_ready=%b valid=%b busy=%b found=%b min=%0d total=%0d expected 1 0 0 0 0 0",
               in_ready, out_valid, busy, out_found, out_min_presses, total_presses);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_m2();
    do_accept();
    wait_valid(edges);
    checks++;
    if (edges !== 33 || out_found !== 1'b1 || out_min_presses !== 4'd3) begin
      failures++;
      $display("FAIL post_reset_result: edges=%0d found=%b min=%0d expected 33 1 3", edges, out_found, out_min_presses);
    end
    do_consume(1'b0);
    checks++;
    if (total_presses !== 32'd3) begin
      failures++;
      $display("FAIL post_reset_total: got %0d expected 3", total_presses);
    end
  endtask

  task automatic test_total_clear();
    int edges;
    load_m1();
    do_accept();
    wait_valid(edges);
    do_consume(1'b1);
    checks++;
    if (total_presses !== 32'd2) begin
      failures++;
      $display("FAIL clear_with_consume: got %0d expected 2", total_presses);
    end
    @(negedge clk);
    total_clear = 1'b1;
    @(posedge clk);
    #1;
    total_clear = 1'b0;
    checks++;
    if (total_presses !== 32'd0) begin
      failures++;
      $display("FAIL clear_idle: got %0d expected 0", total_presses);
    end
  endtask

  task automatic test_masking();
    int edges;
    clear_machine();
    in_num_lights  = 4'd3;
    in_num_buttons = 4'd3;
    in_target      = 10'b0010000011;  // live bits 011, garbage bit 7
    in_buttons[0]  = 10'b0000100001;  // live 001, garbage bit 5
    in_buttons[1]  = 10'b0000000010;
    in_buttons[2]  = 10'b0000100100;  // live 100, garbage bit 5
    in_buttons[3]  = 10'b0000000011;  // beyond num_buttons: must be ignored
    do_accept();
    wait_valid(edges);
    checks++;
    if (edges !== 9 || out_found !== 1'b1 || out_min_presses !== 4'd2) begin
      failures++;
      $display("FAIL masking: edges=%0d found=%b min=%0d expected 9 1 2", edges, out_found, out_min_presses);
    end
    do_consume(1'b0);
    checks++;
    if (total_presses !== 32'd2) begin
      failures++;
      $display("FAIL masking_total: got %0d expected 2", total_presses);
    end
  endtask

  initial begin
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    total_clear = 1'b0;
    clear_machine();
    test_reset();
    test_example();
    test_back_to_back();
    test_unreachable();
    test_zero_buttons();
    test_backpressure();
    test_reset_mid_search();
    test_total_clear();
    test_masking();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
